// File: rtl/lsu_pkg.sv
// Shared constants and state type for the memory-stage load/store unit.
package lsu_pkg;

  // funct3 access modes
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} lsu_state_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a loaded word and extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  mode,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select, then sign/zero extension by mode
  always_comb begin
    byte_lane = mem_rdata[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_data  = mem_rdata;
    case (mode)
      MODE_B:  ext_data = {{24{byte_lane[7]}}, byte_lane};
      MODE_BU: ext_data = {24'h0, byte_lane};
      MODE_H:  ext_data = {{16{half_lane[15]}}, half_lane};
      MODE_HU: ext_data = {16'h0, half_lane};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: issues data-memory requests, stalls while an access is
// outstanding, and registers the MEM/WB outputs (bubble on stall cycles).
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [WIDTH-1:0]      RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic [2:0]            modeAddrM,
  input  logic [DATA_WIDTH-1:0] InstrM,
  output logic                  StallM,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0]      RdW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [DATA_WIDTH-1:0] InstrW,
  output logic                  MisalignW
);

  lsu_state_t state_q, state_d;

  logic        is_store, is_load, mem_op, legal, illegal;
  logic        req_valid, stall, capture;
  logic [1:0]  addr_lo;
  logic [3:0]  strb;
  logic [31:0] load_data;

  assign addr_lo  = ALUResultM[1:0];
  // Store wins when both store and load are flagged
  assign is_store = MemWriteM;
  assign is_load  = (ResultSrcM == RES_MEM) && !MemWriteM;
  assign mem_op   = is_store || is_load;

  // Mode legality and alignment; stores only accept B/H/W
  always_comb begin
    legal = 1'b0;
    case (modeAddrM)
      MODE_B:           legal = 1'b1;
      MODE_BU:          legal = !is_store;
      MODE_H:           legal = !addr_lo[0];
      MODE_HU:          legal = !is_store && !addr_lo[0];
      MODE_W:           legal = (addr_lo == 2'b00);
      default:          legal = 1'b0;
    endcase
  end

  assign illegal = mem_op && !legal;

  // Store strobes and lane-replicated write data
  always_comb begin
    strb      = 4'b1111;
    mem_wdata = WriteDataM;
    case (modeAddrM)
      MODE_B: begin
        strb      = 4'b0001 << addr_lo;
        mem_wdata = {4{WriteDataM[7:0]}};
      end
      MODE_H: begin
        strb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        mem_wdata = WriteDataM;
      end
    endcase
  end

  // Next state, request valid, stall, and W capture decision
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    stall     = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && legal) begin
          req_valid = 1'b1;
          if (mem_req_ready && is_store) begin
            capture = 1'b1;
          end else if (mem_req_ready) begin
            state_d = WAIT_RSP;
            stall   = 1'b1;
          end else begin
            state_d = REQ;
            stall   = 1'b1;
          end
        end else begin
          capture = 1'b1;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        if (mem_req_ready && is_store) begin
          state_d = IDLE;
          capture = 1'b1;
        end else if (mem_req_ready) begin
          state_d = WAIT_RSP;
          stall   = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          capture = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_valid = req_valid && !rst;
  assign StallM        = stall && !rst;
  assign mem_we        = mem_req_valid && is_store;
  assign mem_wstrb     = (mem_req_valid && is_store) ? strb : 4'b0000;
  assign mem_addr      = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

  load_align u_load_align (
    .mem_rdata (mem_rdata[31:0]),
    .addr      (addr_lo),
    .mode      (modeAddrM),
    .ext_data  (load_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // MEM/WB pipeline register; stall cycles insert a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      InstrW     <= '0;
      MisalignW  <= 1'b0;
    end else if (capture) begin
      RegWriteW  <= RegWriteM && !illegal;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_data;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      InstrW     <= InstrM;
      MisalignW  <= illegal;
    end else begin
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with hand-computed expectations.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM;
  logic [4:0]  RdM;
  logic [2:0]  modeAddrM;
  logic        StallM, mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, InstrW;
  logic [4:0]  RdW;

  int total = 0;
  int bad   = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .RegWriteM     (RegWriteM),
    .ResultSrcM    (ResultSrcM),
    .MemWriteM     (MemWriteM),
    .ALUResultM    (ALUResultM),
    .WriteDataM    (WriteDataM),
    .RdM           (RdM),
    .PCPlus4M      (PCPlus4M),
    .modeAddrM     (modeAddrM),
    .InstrM        (InstrM),
    .StallM        (StallM),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .RegWriteW     (RegWriteW),
    .ResultSrcW    (ResultSrcW),
    .ALUResultW    (ALUResultW),
    .ReadDataW     (ReadDataW),
    .RdW           (RdW),
    .PCPlus4W      (PCPlus4W),
    .InstrW        (InstrW),
    .MisalignW     (MisalignW)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw,
                        input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    modeAddrM  = mode;
    ALUResultM = addr;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = addr + 32'h4;
    InstrM     = {27'h0, rd};
  endtask

  initial begin
    rst = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = 32'h0;
    set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0, 32'h0, 5'd1);
    #2;
    check("rst_regwrite", {31'h0, RegWriteW}, 32'h0);
    check("rst_alures", ALUResultW, 32'h0);
    check("rst_stall", {31'h0, StallM}, 32'h0);
    check("rst_reqvalid", {31'h0, mem_req_valid}, 32'h0);
    @(negedge clk);
    set_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5);
    rst = 1'b0;
    #1;
    // ALU op
    check("alu_stall", {31'h0, StallM}, 32'h0);
    check("alu_reqvalid", {31'h0, mem_req_valid}, 32'h0);
    tick();
    check("alu_regwrite", {31'h0, RegWriteW}, 32'h1);
    check("alu_result", ALUResultW, 32'h1234);
    check("alu_rd", {27'h0, RdW}, 32'd5);
    check("alu_pc4", PCPlus4W, 32'h1238);
    // SB
    set_op(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'hAB, 5'd0);
    mem_req_ready = 1'b1;
    #1;
    check("sb_valid", {31'h0, mem_req_valid}, 32'h1);
    check("sb_we", {31'h0, mem_we}, 32'h1);
    check("sb_strb", {28'h0, mem_wstrb}, 32'h8);
    check("sb_addr", mem_addr, 32'h100);
    check("sb_wdata", mem_wdata, 32'hABABABAB);
    check("sb_stall", {31'h0, StallM}, 32'h0);
    tick();
    check("sb_wb_regwrite", {31'h0, RegWriteW}, 32'h0);
    check("sb_wb_alures", ALUResultW, 32'h103);
    // SH upper half, SW
    set_op(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
    #1;
    check("sh_strb", {28'h0, mem_wstrb}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hABCDABCD);
    tick();
    set_op(1'b0, 2'b00, 1'b1, 3'b010, 32'h104, 32'h1234ABCD, 5'd0);
    #1;
    check("sw_strb", {28'h0, mem_wstrb}, 32'hF);
    check("sw_wdata", mem_wdata, 32'h1234ABCD);
    tick();
    // LB then LBU at 0x102, rsp one cycle after accept
    for (int k = 0; k < 2; k++) begin
      set_op(1'b1, 2'b01, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h102, 32'h0, 5'd7);
      mem_req_ready = 1'b1;
      #1;
      check("lb_valid", {31'h0, mem_req_valid}, 32'h1);
      check("lb_we", {31'h0, mem_we}, 32'h0);
      check("lb_strb", {28'h0, mem_wstrb}, 32'h0);
      check("lb_stall", {31'h0, StallM}, 32'h1);
      tick();
      check("lb_bubble", {31'h0, RegWriteW}, 32'h0);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata = 32'h00800000;
      #1;
      check("lb_rsp_stall", {31'h0, StallM}, 32'h0);
      tick();
      mem_rsp_valid = 1'b0;
      check("lb_regwrite", {31'h0, RegWriteW}, 32'h1);
      check("lb_data", ReadDataW, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      check("lb_rd", {27'h0, RdW}, 32'd7);
      check("lb_src", {30'h0, ResultSrcW}, 32'h1);
    end
    // LH / LHU upper half
    for (int k = 0; k < 2; k++) begin
      set_op(1'b1, 2'b01, 1'b0, (k == 0) ? 3'b001 : 3'b101, 32'h102, 32'h0, 5'd8);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata = 32'h80010000;
      tick();
      mem_rsp_valid = 1'b0;
      check("lh_data", ReadDataW, (k == 0) ? 32'hFFFF8001 : 32'h00008001);
    end
    // LW with 3 not-ready cycles, rsp 2 cycles after accept
    set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 5'd9);
    mem_req_ready = 1'b0;
    mem_rdata = 32'h0;
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      mem_req_ready = (c == 3);
      mem_rsp_valid = (c == 5);
      if (c == 5) mem_rdata = 32'hDEADBEEF;
      #1;
      if (c < 4) begin
        check("lw_valid", {31'h0, mem_req_valid}, 32'h1);
        check("lw_addr", mem_addr, 32'h200);
        check("lw_we", {31'h0, mem_we}, 32'h0);
      end
      if (StallM) stall_cnt++;
      tick();
      if (c < 5) check("lw_bubble", {31'h0, RegWriteW}, 32'h0);
    end
    mem_rsp_valid = 1'b0;
    check("lw_stall_cycles", stall_cnt, 32'd5);
    check("lw_regwrite", {31'h0, RegWriteW}, 32'h1);
    check("lw_data", ReadDataW, 32'hDEADBEEF);
    // Misaligned LH and illegal mode 011
    for (int k = 0; k < 2; k++) begin
      set_op(1'b1, 2'b01, 1'b0, (k == 0) ? 3'b001 : 3'b011, (k == 0) ? 32'h101 : 32'h100,
             32'h0, 5'd10);
      mem_req_ready = 1'b1;
      #1;
      check("mis_valid", {31'h0, mem_req_valid}, 32'h0);
      check("mis_stall", {31'h0, StallM}, 32'h0);
      tick();
      check("mis_flag", {31'h0, MisalignW}, 32'h1);
      check("mis_regwrite", {31'h0, RegWriteW}, 32'h0);
      check("mis_rd", {27'h0, RdW}, 32'd10);
    end
    set_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3);
    tick();
    check("mis_clear", {31'h0, MisalignW}, 32'h0);
    // Reset during WAIT_RSP
    set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 5'd11);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw_regwrite", {31'h0, RegWriteW}, 32'h0);
    check("rstw_rd", {27'h0, RdW}, 32'h0);
    check("rstw_alures", ALUResultW, 32'h0);
    check("rstw_stall", {31'h0, StallM}, 32'h0);
    tick();
    set_op(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h12345678;
    #1;
    check("rstw_rsp_stall", {31'h0, StallM}, 32'h0);
    tick();
    mem_rsp_valid = 1'b0;
    check("rstw_rsp_regwrite", {31'h0, RegWriteW}, 32'h0);
    // A fresh load must see IDLE (request issued immediately)
    set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h400, 32'h0, 5'd12);
    mem_req_ready = 1'b0;
    #1;
    check("rstw_idle_req", {31'h0, mem_req_valid}, 32'h1);
    check("rstw_idle_stall", {31'h0, StallM}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
